packet_sort_module: RTL and testbench

- Streaming packet sorter.
- Accepts one packet of up to 2^ADR_WIDTH unsigned words on a sop/eop/valid input stream and stores it internally.
- Sorts the words in ascending order, then emits the sorted packet on an identical sop/eop/valid output stream.
- Sits between a packet source and a downstream consumer; busy_o tells the source that input is being ignored.

---
 rtl/packet_sort_module.sv | 163 ++++++++++++++++
 tb/tb_packet_sort_module.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/packet_sort_module.sv
// Streaming packet sorter: buffers one packet of up to 2**ADR_WIDTH words, sorts it
// ascending with odd-even transposition, then replays it on a sop/eop/valid stream.
module packet_sort_module #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADR_WIDTH  = 3
) (
  input  logic                  clk_i,
  input  logic                  async_rst_i,
  input  logic                  sop_i,
  input  logic                  eop_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  val_i,
  output logic                  sop_o,
  output logic                  eop_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  val_o,
  output logic                  busy_o
);

  localparam int unsigned N = 2 ** ADR_WIDTH;

  typedef enum logic [1:0] {StIdle, StRecv, StSort, StSend} state_e;

  state_e                state_q, state_d;
  logic [ADR_WIDTH:0]    len_q, len_d;
  // Pass index while sorting, word index while sending.
  logic [ADR_WIDTH:0]    cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] mem_q [N];
  logic [DATA_WIDTH-1:0] mem_d [N];

  logic                  sop_q, sop_d;
  logic                  eop_q, eop_d;
  logic                  val_q, val_d;
  logic                  busy_q, busy_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  logic [ADR_WIDTH-1:0]  wr_idx;
  logic [ADR_WIDTH-1:0]  rd_idx;
  logic [ADR_WIDTH:0]    len_one;

  assign wr_idx  = len_q[ADR_WIDTH-1:0];
  assign rd_idx  = cnt_q[ADR_WIDTH-1:0];
  assign len_one = {{ADR_WIDTH{1'b0}}, 1'b1};

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    mem_d   = mem_q;
    sop_d   = 1'b0;
    eop_d   = 1'b0;
    val_d   = 1'b0;
    data_d  = '0;
    busy_d  = busy_q;

    unique case (state_q)
      StIdle: begin
        if (val_i && sop_i) begin
          mem_d[0] = data_i;
          len_d    = len_one;
          cnt_d    = '0;
          if (eop_i) begin
            state_d = StSort;
            busy_d  = 1'b1;
          end else begin
            state_d = StRecv;
          end
        end
      end

      StRecv: begin
        if (val_i) begin
          cnt_d = '0;
          if (sop_i) begin
            mem_d[0] = data_i;
            len_d    = len_one;
            if (eop_i) begin
              state_d = StSort;
              busy_d  = 1'b1;
            end
          end else begin
            mem_d[wr_idx] = data_i;
            len_d         = len_q + len_one;
            // A full buffer closes the packet even without eop.
            if (eop_i || (wr_idx == '1)) begin
              state_d = StSort;
              busy_d  = 1'b1;
            end
          end
        end
      end

      StSort: begin
        for (int i = 0; i < int'(N) - 1; i++) begin
          if ((i[0] == cnt_q[0]) && (i + 1 < int'(len_q)) && (mem_q[i] > mem_q[i+1])) begin
            mem_d[i]   = mem_q[i+1];
            mem_d[i+1] = mem_q[i];
          end
        end
        if (cnt_q == len_q - len_one) begin
          state_d = StSend;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + len_one;
        end
      end

      StSend: begin
        if (cnt_q == len_q) begin
          state_d = StIdle;
          busy_d  = 1'b0;
          len_d   = '0;
          cnt_d   = '0;
        end else begin
          val_d  = 1'b1;
          data_d = mem_q[rd_idx];
          sop_d  = (cnt_q == '0);
          eop_d  = (cnt_q == len_q - len_one);
          cnt_d  = cnt_q + len_one;
        end
      end

      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge async_rst_i) begin
    if (async_rst_i) begin
      state_q <= StIdle;
      len_q   <= '0;
      cnt_q   <= '0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      val_q   <= 1'b0;
      busy_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      val_q   <= val_d;
      busy_q  <= busy_d;
      data_q  <= data_d;
    end
  end

  // Packet storage needs no reset; contents are only read after being written.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign sop_o  = sop_q;
  assign eop_o  = eop_q;
  assign val_o  = val_q;
  assign busy_o = busy_q;
  assign data_o = data_q;

endmodule

// File: tb/tb_packet_sort_module.sv
// Scoreboard bench for packet_sort_module: sorted packets are queued at stimulus time
// and popped as the sorter streams them out.
module tb_packet_sort_module;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sop_i = 1'b0;
  logic       eop_i = 1'b0;
  logic       val_i = 1'b0;
  logic [7:0] data_i = 8'h00;
  logic       sop_o, eop_o, val_o, busy_o;
  logic [7:0] data_o;

  int total  = 0;
  int passed = 0;

  typedef struct packed {
    logic [7:0] d;
    logic       s;
    logic       e;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] pkt[$];

  always #5 clk = ~clk;

  packet_sort_module #(
    .DATA_WIDTH(8),
    .ADR_WIDTH (3)
  ) dut (
    .clk_i      (clk),
    .async_rst_i(rst),
    .sop_i      (sop_i),
    .eop_i      (eop_i),
    .data_i     (data_i),
    .val_i      (val_i),
    .sop_o      (sop_o),
    .eop_o      (eop_o),
    .data_o     (data_o),
    .val_o      (val_o),
    .busy_o     (busy_o)
  );

  task automatic drive(input logic v, input logic s, input logic e, input logic [7:0] d);
    @(negedge clk);
    val_i  = v;
    sop_i  = s;
    eop_i  = e;
    data_i = d;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic send_pkt(input bit with_eop);
    for (int i = 0; i < pkt.size(); i++)
      drive(1'b1, i == 0, with_eop && (i == pkt.size() - 1), pkt[i]);
  endtask

  task automatic push_sorted();
    logic [7:0] a[$];
    logic [7:0] t;
    a = pkt;
    for (int i = 1; i < a.size(); i++)
      for (int j = i; j > 0; j--)
        if (a[j-1] > a[j]) begin
          t = a[j]; a[j] = a[j-1]; a[j-1] = t;
        end
    for (int k = 0; k < a.size(); k++)
      sb.push_back('{d: a[k], s: (k == 0), e: (k == a.size() - 1)});
  endtask

  // Pops the scoreboard as words appear; lat is the expected negedge index of the first word.
  task automatic collect(input int lat, input int budget);
    int   i = 0;
    bit   started = 0;
    exp_t e;
    while (sb.size() > 0 && i < budget) begin
      @(negedge clk);
      i++;
      if (val_o) begin
        if (!started) begin
          started = 1;
          if (lat > 0) begin
            total++;
            if (i !== lat) $display("FAIL first_latency: got %0d want %0d", i, lat);
            else passed++;
          end
        end
        e = sb.pop_front();
        total++;
        if ({data_o, sop_o, eop_o} !== {e.d, e.s, e.e})
          $display("FAIL out_word: got data=%h sop=%b eop=%b want data=%h sop=%b eop=%b",
                   data_o, sop_o, eop_o, e.d, e.s, e.e);
        else passed++;
      end else if (started) begin
        total++;
        $display("FAIL out_gap: val_o=0 with %0d words still expected", sb.size());
      end
    end
    if (sb.size() > 0) begin
      total++;
      $display("FAIL out_timeout: %0d words never appeared, want 0", sb.size());
      sb.delete();
    end
  endtask

  // Closes input, checks busy rise, drains output, checks return to idle.
  task automatic finish_packet(input int lat, input bit extra, input bit intrude);
    push_sorted();
    if (extra) drive(1'b1, 1'b1, 1'b1, 8'h77);
    else idle();
    total++;
    if (busy_o !== 1'b1) $display("FAIL busy_rise: got %b want 1", busy_o);
    else passed++;
    if (extra) idle();
    if (intrude) begin
      fork
        begin
          drive(1'b1, 1'b1, 1'b0, 8'h01);
          drive(1'b1, 1'b0, 1'b0, 8'h02);
          drive(1'b1, 1'b0, 1'b1, 8'h03);
          idle();
        end
        collect(lat, lat + 16);
      join
    end else begin
      collect(lat, lat + 16);
    end
    @(negedge clk);
    total++;
    if ({busy_o, val_o, sop_o, eop_o, data_o} !== 12'h000)
      $display("FAIL end_idle: got busy=%b val=%b sop=%b eop=%b data=%h want all 0",
               busy_o, val_o, sop_o, eop_o, data_o);
    else passed++;
  endtask

  task automatic expect_quiet(input int cycles);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (val_o || busy_o) seen++;
    end
    total++;
    if (seen !== 0) $display("FAIL quiet: got %0d active cycles want 0", seen);
    else passed++;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++;
    if (val_o !== 1'b0) $display("FAIL rst_val: got %b want 0", val_o); else passed++;
    total++;
    if (sop_o !== 1'b0) $display("FAIL rst_sop: got %b want 0", sop_o); else passed++;
    total++;
    if (eop_o !== 1'b0) $display("FAIL rst_eop: got %b want 0", eop_o); else passed++;
    total++;
    if (busy_o !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy_o); else passed++;
    total++;
    if (data_o !== 8'h00) $display("FAIL rst_data: got %h want 00", data_o); else passed++;
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_sort8();
    pkt = '{8'hFA, 8'hAA, 8'h56, 8'h12, 8'hAD, 8'hC8, 8'hBC, 8'h05};
    send_pkt(1);
    total++;
    if (busy_o !== 1'b0) $display("FAIL busy_early: got %b want 0", busy_o); else passed++;
    finish_packet(9, 0, 0);
  endtask

  task automatic test_single();
    pkt = '{8'hFF};
    send_pkt(1);
    finish_packet(2, 0, 0);
  endtask

  task automatic test_two_word();
    repeat (4) idle();
    pkt = '{8'hFF, 8'hAA};
    send_pkt(1);
    finish_packet(3, 0, 0);
  endtask

  task automatic test_overflow();
    pkt = '{8'h90, 8'h10, 8'h80, 8'h20, 8'h70, 8'h30, 8'h60, 8'h40};
    send_pkt(0);
    finish_packet(0, 1, 0);
    expect_quiet(6);
  endtask

  task automatic test_busy_ignored();
    pkt = '{8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};
    send_pkt(1);
    finish_packet(9, 0, 1);
    expect_quiet(8);
  endtask

  task automatic test_gap_restart();
    drive(1'b1, 1'b1, 1'b0, 8'h10);
    drive(1'b1, 1'b0, 1'b0, 8'h20);
    idle();
    drive(1'b1, 1'b0, 1'b0, 8'h30);
    drive(1'b1, 1'b1, 1'b0, 8'h33);
    idle();
    idle();
    drive(1'b1, 1'b0, 1'b0, 8'h07);
    drive(1'b1, 1'b0, 1'b1, 8'h99);
    pkt = '{8'h33, 8'h07, 8'h99};
    finish_packet(4, 0, 0);
  endtask

  task automatic test_dups();
    idle();
    drive(1'b1, 1'b0, 1'b0, 8'hEE);
    pkt = '{8'h40, 8'h11, 8'h40, 8'h11, 8'h00};
    send_pkt(1);
    finish_packet(6, 0, 0);
  endtask

  task automatic test_midsend_reset();
    int i = 0;
    pkt = '{8'hFA, 8'hAA, 8'h56, 8'h12, 8'hAD, 8'hC8, 8'hBC, 8'h05};
    send_pkt(1);
    idle();
    while (!val_o && i < 30) begin
      @(negedge clk);
      i++;
    end
    total++;
    if (val_o !== 1'b1) $display("FAIL midsend_start: val_o got %b want 1", val_o);
    else passed++;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if ({busy_o, val_o, sop_o, eop_o, data_o} !== 12'h000)
      $display("FAIL midsend_rst: got busy=%b val=%b sop=%b eop=%b data=%h want all 0",
               busy_o, val_o, sop_o, eop_o, data_o);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    expect_quiet(4);
    pkt = '{8'h9C, 8'h03, 8'hC9, 8'h30};
    send_pkt(1);
    finish_packet(5, 0, 0);
  endtask

  initial begin
    test_reset();
    test_sort8();
    test_single();
    test_two_word();
    test_overflow();
    test_busy_ignored();
    test_gap_restart();
    test_dups();
    test_midsend_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
